// File: rtl/afpm_pcpi_mul.sv
// PCPI front end for the combinational approximate FP32 multiplier core:
// decodes FMUL, launches operands, samples the product after LATENCY cycles.
module afpm_pcpi_mul #(
    parameter int unsigned LATENCY = 1,  // 1..15, fits the 4-bit countdown
    parameter logic [6:0]  OPCODE  = 7'b0001011,
    parameter logic [2:0]  FUNCT3  = 3'b000,
    parameter logic [6:0]  FUNCT7  = 7'b0000101
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        pcpi_valid,
    input  logic [31:0] pcpi_insn,
    input  logic [31:0] pcpi_rs1,
    input  logic [31:0] pcpi_rs2,
    output logic        pcpi_wr,
    output logic [31:0] pcpi_rd,
    output logic        pcpi_wait,
    output logic        pcpi_ready,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    input  logic [31:0] mul_p,
    output logic        busy,
    output logic [31:0] op_count
);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t      r_state, w_next;
    logic        r_armed;
    logic [3:0]  r_cnt;
    logic        r_ready, r_wr, r_busy;
    logic [31:0] r_rd, r_mul_a, r_mul_b, r_op_count;
    logic        w_match, w_launch, w_capture;

    assign w_match = pcpi_valid
                   && pcpi_insn[6:0]   == OPCODE
                   && pcpi_insn[14:12] == FUNCT3
                   && pcpi_insn[31:25] == FUNCT7;

    assign pcpi_wait  = w_match && (r_state != S_IDLE || r_armed);
    assign pcpi_ready = r_ready;
    assign pcpi_wr    = r_wr;
    assign pcpi_rd    = r_rd;
    assign mul_a      = r_mul_a;
    assign mul_b      = r_mul_b;
    assign busy       = r_busy;
    assign op_count   = r_op_count;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_match && r_armed) w_next = S_CALC;
            S_CALC: begin
                if (!pcpi_valid)       w_next = S_IDLE;
                else if (r_cnt == 4'd0) w_next = S_DONE;
            end
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    assign w_launch  = (r_state == S_IDLE) && (w_next == S_CALC);
    assign w_capture = (r_state == S_CALC) && (w_next == S_DONE);

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state    <= S_IDLE;
            r_armed    <= 1'b1;
            r_cnt      <= 4'd0;
            r_ready    <= 1'b0;
            r_wr       <= 1'b0;
            r_busy     <= 1'b0;
            r_rd       <= 32'd0;
            r_mul_a    <= 32'd0;
            r_mul_b    <= 32'd0;
            r_op_count <= 32'd0;
        end else begin
            r_state <= w_next;
            r_ready <= (w_next == S_DONE);
            r_wr    <= (w_next == S_DONE);
            r_busy  <= (w_next != S_IDLE);
            r_rd    <= w_capture ? mul_p : 32'd0;

            if (w_launch) begin
                r_mul_a <= pcpi_rs1;
                r_mul_b <= pcpi_rs2;
                r_cnt   <= 4'(LATENCY - 1);
            end else if (r_state == S_CALC && pcpi_valid && r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end

            // Disarm after completion so the still-high valid cannot relaunch.
            if (r_state == S_DONE) begin
                r_op_count <= r_op_count + 32'd1;
                r_armed    <= 1'b0;
            end else if (!pcpi_valid && r_state != S_DONE) begin
                r_armed <= 1'b1;
            end
        end
    end

endmodule
